instruction_queue_unit: RTL and testbench
=========================================

INSTRUCTION_QUEUE_UNIT -- requirements
Module: instruction_queue_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning instruction/data width.
REQ-002 SHALL have parameter ADDRESS_BITS, default 20, meaning PC/address width.
REQ-003 SHALL have parameter DEPTH, default 8, meaning queue entries (power of two, >=2).
REQ-004 SHALL define local PACKET_WIDTH = DATA_WIDTH + 3*ADDRESS_BITS + 38 (130 at defaults).
REQ-005 SHALL have port clock  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port valid_in  input  1  decode-pipe packet valid.
REQ-008 SHALL have port packet_in  input  PACKET_WIDTH  decoded packet from decode pipe.
REQ-009 SHALL have port flush  input  1  writeback redirect (branch/JALR taken), discard all queued packets.
REQ-010 SHALL have port issue_ready  input  1  execute stage accepts head packet this cycle.
REQ-011 SHALL have port issue_valid  output  1  head packet valid.
REQ-012 SHALL have port packet_issue  output  PACKET_WIDTH  head packet.
REQ-013 SHALL have port full  output  1  no free entry; decode must stall.
REQ-014 SHALL have port empty  output  1  no valid entry.
REQ-015 SHALL have port count  output  log2(DEPTH)+1  occupied entries.
REQ-016 SHALL have port overflow  output  1  sticky: packet presented while full.

Function
REQ-017 SHALL hold DEPTH entries in a circular buffer with write pointer, read pointer and occupancy counter, all wrapping modulo DEPTH.
REQ-018 SHALL accept (push) when valid_in=1 and full=0 at the rising edge; packet stored at write pointer, write pointer +1.
REQ-019 SHALL pop when issue_valid=1 and issue_ready=1 at the rising edge; read pointer +1.
REQ-020 SHALL present head combinationally: issue_valid = !empty, packet_issue = entry at read pointer (first-word fall-through).
REQ-021 SHALL give push-to-issue latency of exactly 1 cycle; no same-cycle bypass when empty.
REQ-022 SHALL, on simultaneous push and pop with 0<count<DEPTH, perform both and leave count unchanged.
REQ-023 SHALL, when full, reject valid_in even if a pop occurs same cycle; count decrements by 1; rejected packet lost.
REQ-024 SHALL set overflow to 1 on any edge where valid_in=1 and full=1 and flush=0; overflow stays 1 until reset.
REQ-025 SHALL ignore issue_ready while empty; no pointer or count change.
REQ-026 SHALL give flush priority over push and pop: on flush=1, both pointers and count go to 0 next cycle; packet_in and pop that cycle discarded; overflow unchanged.
REQ-027 SHALL drive full = (count==DEPTH), empty = (count==0), both derived from registered count.
REQ-028 SHALL keep count in range 0..DEPTH at all times.
REQ-029 SHALL leave entry storage contents unspecified after pop/flush; only pointer/count define validity.

Reset
REQ-030 SHALL, on reset=1 at a rising edge, set pointers=0, count=0, overflow=0; reset overrides flush, push, pop.
REQ-031 SHALL present after reset: issue_valid=0, empty=1, full=0, count=0, overflow=0; packet_issue value don't-care.
REQ-032 SHALL, on reset asserted mid-operation with entries queued, discard all entries; first post-reset push issues 1 cycle later.

Verification
REQ-033 Single: after reset, push packet 0xA5 (zero-extended) with issue_ready=0 -> next cycle issue_valid=1, packet_issue=0xA5, count=1; assert issue_ready one cycle -> empty=1.
REQ-034 Fill/wrap: push 8 packets 1..8, issue_ready=0 -> full=1, count=8; pop 3, push 9..11 -> issue order 4..11, pointers wrapped.
REQ-035 Full push+pop: count=8, valid_in=1 (packet 0x99), issue_ready=1 -> count=7, overflow=1, 0x99 never issued.
REQ-036 Steady stream: valid_in=1 and issue_ready=1 every cycle for 20 cycles -> count stays 1, packets issued in order, no loss.
REQ-037 Flush: count=5, flush=1 with valid_in=1 and issue_ready=1 -> next cycle count=0, empty=1, issue_valid=0; flushed packets never issued.
REQ-038 Reset mid-run: count=6, overflow=1, assert reset with flush=1 -> count=0, overflow=0, empty=1.

Source files
------------

// File: rtl/instruction_queue_unit_if.sv
// Decode-to-issue handshake bundle for the instruction queue.
// The master side is the decode pipe and execute stage; the slave side is the queue.
interface instruction_queue_unit_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int DEPTH        = 8
);
  localparam int PACKET_WIDTH = DATA_WIDTH + 3 * ADDRESS_BITS + 38;
  localparam int COUNT_WIDTH  = $clog2(DEPTH) + 1;

  logic                    valid_in;
  logic [PACKET_WIDTH-1:0] packet_in;
  logic                    flush;
  logic                    issue_ready;
  logic                    issue_valid;
  logic [PACKET_WIDTH-1:0] packet_issue;
  logic                    full;
  logic                    empty;
  logic [COUNT_WIDTH-1:0]  count;
  logic                    overflow;

  modport master (
    output valid_in, packet_in, flush, issue_ready,
    input  issue_valid, packet_issue, full, empty, count, overflow
  );

  modport slave (
    input  valid_in, packet_in, flush, issue_ready,
    output issue_valid, packet_issue, full, empty, count, overflow
  );
endinterface

// File: rtl/instruction_queue_unit.sv
// Circular first-word-fall-through queue between decode and execute.
// A flush discards every queued packet; overflow is a sticky drop indicator.
module instruction_queue_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int DEPTH        = 8
) (
  input logic                      clock,
  input logic                      reset,
  instruction_queue_unit_if.slave  iq
);
  localparam int PACKET_WIDTH = DATA_WIDTH + 3 * ADDRESS_BITS + 38;
  localparam int PTR_WIDTH    = $clog2(DEPTH);
  localparam int COUNT_WIDTH  = PTR_WIDTH + 1;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = COUNT_WIDTH'(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [PTR_WIDTH-1:0]   PTR_ONE    = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0]   PTR_ZERO   = {PTR_WIDTH{1'b0}};

  logic [PACKET_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   overflow_q, overflow_d;
  logic                   push_s, pop_s, write_en_s;

  // Next-state: reset beats flush, flush beats push/pop; full blocks push even when popping.
  always_comb begin
    push_s     = iq.valid_in & ~full_q;
    pop_s      = iq.issue_ready & ~empty_q;
    write_en_s = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (reset) begin
      wr_ptr_d   = PTR_ZERO;
      rd_ptr_d   = PTR_ZERO;
      count_d    = COUNT_ZERO;
      overflow_d = 1'b0;
    end else if (iq.flush) begin
      wr_ptr_d   = PTR_ZERO;
      rd_ptr_d   = PTR_ZERO;
      count_d    = COUNT_ZERO;
      overflow_d = overflow_q;
    end else begin
      write_en_s = push_s;

      if (iq.valid_in & full_q) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end

      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + COUNT_ONE;
        2'b01:   count_d = count_q - COUNT_ONE;
        default: count_d = count_q;
      endcase
    end

    full_d  = (count_d == COUNT_MAX);
    empty_d = (count_d == COUNT_ZERO);
  end

  // Control state registers; reset is already folded into the _d values.
  always_ff @(posedge clock) begin
    wr_ptr_q   <= wr_ptr_d;
    rd_ptr_q   <= rd_ptr_d;
    count_q    <= count_d;
    full_q     <= full_d;
    empty_q    <= empty_d;
    overflow_q <= overflow_d;
  end

  // Packet storage; contents are don't-care outside the rd..wr window.
  always_ff @(posedge clock) begin
    if (write_en_s) begin
      mem_q[wr_ptr_q] <= iq.packet_in;
    end
  end

  assign iq.issue_valid  = ~empty_q;
  assign iq.packet_issue = mem_q[rd_ptr_q];
  assign iq.full         = full_q;
  assign iq.empty        = empty_q;
  assign iq.count        = count_q;
  assign iq.overflow     = overflow_q;
endmodule

// File: tb/tb_instruction_queue_unit.sv
// Directed bench for instruction_queue_unit: a queue-based model checked every cycle,
// plus hand-computed literal expectations along the directed scenarios.
module tb_instruction_queue_unit;
  localparam int DATA_WIDTH   = 32;
  localparam int ADDRESS_BITS = 20;
  localparam int DEPTH        = 8;
  localparam int PW           = DATA_WIDTH + 3 * ADDRESS_BITS + 38;

  logic clock;
  logic reset;

  instruction_queue_unit_if #(
    .DATA_WIDTH(DATA_WIDTH), .ADDRESS_BITS(ADDRESS_BITS), .DEPTH(DEPTH)
  ) bus ();

  instruction_queue_unit #(
    .DATA_WIDTH(DATA_WIDTH), .ADDRESS_BITS(ADDRESS_BITS), .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .iq   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0] mq[$];
  bit            m_ovf    = 1'b0;
  bit            model_on = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural queue update for one rising edge.
  task automatic apply_model(input logic v, input logic [PW-1:0] p, input logic fl,
                             input logic rdy, input logic rst);
    bit was_full;
    bit was_empty;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (fl) begin
      mq.delete();
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (v && was_full) m_ovf = 1'b1;
      if (rdy && !was_empty) void'(mq.pop_front());
      if (v && !was_full) mq.push_back(p);
    end
  endtask

  task automatic step(input logic v, input logic [PW-1:0] p, input logic fl,
                      input logic rdy, input logic rst);
    bus.valid_in    = v;
    bus.packet_in   = p;
    bus.flush       = fl;
    bus.issue_ready = rdy;
    reset           = rst;
    @(posedge clock);
    apply_model(v, p, fl, rdy, rst);
    if (rst) model_on = 1'b1;
    @(negedge clock);
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (model_on) begin
      checks++;
      if (bus.issue_valid !== (mq.size() != 0)) begin
        failures++;
        $display("FAIL issue_valid: got %0b expected %0b", bus.issue_valid, mq.size() != 0);
      end
      checks++;
      if (int'(bus.count) != mq.size() || $isunknown(bus.count)) begin
        failures++;
        $display("FAIL count: got %0d expected %0d", bus.count, mq.size());
      end
      checks++;
      if (bus.full !== (mq.size() == DEPTH)) begin
        failures++;
        $display("FAIL full: got %0b expected %0b", bus.full, mq.size() == DEPTH);
      end
      checks++;
      if (bus.empty !== (mq.size() == 0)) begin
        failures++;
        $display("FAIL empty: got %0b expected %0b", bus.empty, mq.size() == 0);
      end
      checks++;
      if (bus.overflow !== m_ovf) begin
        failures++;
        $display("FAIL overflow: got %0b expected %0b", bus.overflow, m_ovf);
      end
      if (mq.size() != 0) begin
        checks++;
        if (bus.packet_issue !== mq[0]) begin
          failures++;
          $display("FAIL packet_issue: got %0h expected %0h", bus.packet_issue, mq[0]);
        end
      end
    end
  end

  logic [PW-1:0] z = '0;

  initial begin
    bus.valid_in = 1'b0; bus.packet_in = '0; bus.flush = 1'b0; bus.issue_ready = 1'b0;
    reset = 1'b1;
    step(1'b0, z, 1'b0, 1'b0, 1'b1);
    step(1'b0, z, 1'b0, 1'b0, 1'b1);
    chk("reset_empty", bus.empty, 1);
    chk("reset_issue_valid", bus.issue_valid, 0);
    chk("reset_count", bus.count, 0);
    chk("reset_overflow", bus.overflow, 0);

    // Single packet, one-cycle latency, then pop.
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("single_valid", bus.issue_valid, 1);
    chk("single_packet", bus.packet_issue, 8'hA5);
    chk("single_count", bus.count, 1);
    step(1'b0, z, 1'b0, 1'b1, 1'b0);
    chk("single_empty", bus.empty, 1);

    // issue_ready while empty has no effect.
    step(1'b0, z, 1'b0, 1'b1, 1'b0);
    chk("empty_ready_count", bus.count, 0);

    // Fill and wrap.
    for (int i = 1; i <= 8; i++) step(1'b1, PW'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.count, 8);
    for (int i = 1; i <= 3; i++) begin
      chk("fill_pop_order", bus.packet_issue, PW'(i));
      step(1'b0, z, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 9; i <= 11; i++) step(1'b1, PW'(i), 1'b0, 1'b0, 1'b0);
    chk("wrap_full", bus.full, 1);
    chk("wrap_head", bus.packet_issue, PW'(4));

    // Push while full with a pop: packet dropped, overflow set.
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    chk("fullpp_count", bus.count, 7);
    chk("fullpp_overflow", bus.overflow, 1);
    for (int i = 5; i <= 11; i++) begin
      chk("wrap_order", bus.packet_issue, PW'(i));
      step(1'b0, z, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_empty", bus.empty, 1);

    // Steady stream: count holds at 1, order preserved.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, PW'(100 + i), 1'b0, 1'b1, 1'b0);
      chk("stream_count", bus.count, 1);
      chk("stream_head", bus.packet_issue, PW'(100 + i));
    end
    step(1'b0, z, 1'b0, 1'b1, 1'b0);
    chk("stream_drain", bus.empty, 1);

    // Flush with concurrent push and pop.
    for (int i = 0; i < 5; i++) step(1'b1, PW'(200 + i), 1'b0, 1'b0, 1'b0);
    chk("flush_pre_count", bus.count, 5);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    chk("flush_count", bus.count, 0);
    chk("flush_empty", bus.empty, 1);
    chk("flush_issue_valid", bus.issue_valid, 0);
    chk("flush_overflow_kept", bus.overflow, 1);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("post_flush_head", bus.packet_issue, 8'h3C);
    step(1'b0, z, 1'b0, 1'b1, 1'b0);

    // Reset mid-run with flush also asserted.
    for (int i = 0; i < 9; i++) step(1'b1, PW'(300 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, z, 1'b0, 1'b1, 1'b0);
    step(1'b0, z, 1'b0, 1'b1, 1'b0);
    chk("prereset_count", bus.count, 6);
    chk("prereset_overflow", bus.overflow, 1);
    step(1'b1, 8'h44, 1'b1, 1'b1, 1'b1);
    chk("midreset_count", bus.count, 0);
    chk("midreset_overflow", bus.overflow, 0);
    chk("midreset_empty", bus.empty, 1);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("post_reset_head", bus.packet_issue, 8'h55);
    chk("post_reset_count", bus.count, 1);
    step(1'b0, z, 1'b0, 1'b1, 1'b0);
    step(1'b0, z, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
